// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a prefetch queue and multiple outstanding reads.
// Stale responses after a redirect are dropped by a drain counter.
module fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic [31:0] NEW_PC,
    input  logic        STALL,
    input  logic        MEM_WAIT,
    output logic        INST_RDEN,
    output logic [31:0] INST_RIADDR,
    input  logic [31:0] INST_ROADDR,
    input  logic        INST_RVALID,
    input  logic [31:0] INST_RDATA,
    output logic [31:0] INST_PC,
    output logic [31:0] INST_DATA,
    output logic        INST_VALID
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [31:0]   pc_q;
    logic [31:0]   data_q;
    logic          valid_q;

    logic [CW:0] credits;
    logic        hold;
    logic        issue;
    logic        drop_rsp;
    logic        push;
    logic        pop;

    always_comb begin
        credits  = {1'b0, count} + {1'b0, inflight};
        hold     = STALL || MEM_WAIT;
        issue    = !RST && !FLUSH && !MEM_WAIT
                   && (credits < (CW+1)'(DEPTH));
        drop_rsp = INST_RVALID && (FLUSH || drop != '0);
        push     = INST_RVALID && !drop_rsp;
        pop      = !FLUSH && !hold && count != '0;
    end

    assign INST_RDEN   = issue;
    assign INST_RIADDR = fetch_pc;
    assign INST_PC     = pc_q;
    assign INST_DATA   = data_q;
    assign INST_VALID  = valid_q;

    // Storage needs no reset; occupancy is tracked by count and pointers.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            q_pc[wr_ptr]   <= INST_ROADDR;
            q_data[wr_ptr] <= INST_RDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= START_ADDR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            pc_q     <= '0;
            data_q   <= NOP;
            valid_q  <= 1'b0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(INST_RVALID);
            if (FLUSH) begin
                // Every request still in flight belongs to the old stream.
                fetch_pc <= NEW_PC;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= inflight - CW'(INST_RVALID);
                pc_q     <= NEW_PC;
                data_q   <= NOP;
                valid_q  <= 1'b0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (INST_RVALID && drop != '0)
                    drop <= drop - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (!hold) begin
                    if (pop) begin
                        pc_q    <= q_pc[rd_ptr];
                        data_q  <= q_data[rd_ptr];
                        valid_q <= 1'b1;
                    end else begin
                        data_q  <= NOP;
                        valid_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: DEPTH=4 main instance plus a DEPTH=2
// instance starting near the top of the address space.
module tb_fetch_queue;

    localparam int          D   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, STALL, MEM_WAIT;
    logic [31:0] NEW_PC;
    logic        INST_RDEN, INST_RVALID, INST_VALID;
    logic [31:0] INST_RIADDR, INST_ROADDR, INST_RDATA, INST_PC, INST_DATA;

    logic        flush2, stall2, mw2, rden2, rvalid2, valid2;
    logic [31:0] newpc2, riaddr2, roaddr2, rdata2, pc2, data2;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    fetch_queue #(.DEPTH(4), .START_ADDR(32'h0), .NOP(NOP)) u_dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
        .STALL(STALL), .MEM_WAIT(MEM_WAIT),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
        .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID),
        .INST_RDATA(INST_RDATA), .INST_PC(INST_PC),
        .INST_DATA(INST_DATA), .INST_VALID(INST_VALID)
    );

    fetch_queue #(.DEPTH(2), .START_ADDR(32'hFFFF_FFF8), .NOP(NOP)) u_d2 (
        .CLK(CLK), .RST(RST), .FLUSH(flush2), .NEW_PC(newpc2),
        .STALL(stall2), .MEM_WAIT(mw2),
        .INST_RDEN(rden2), .INST_RIADDR(riaddr2),
        .INST_ROADDR(roaddr2), .INST_RVALID(rvalid2),
        .INST_RDATA(rdata2), .INST_PC(pc2),
        .INST_DATA(data2), .INST_VALID(valid2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h5A5A};
    endfunction

    // memory model + scoreboard for the main instance
    logic [31:0] pend_a[$];
    int          pend_due[$];
    logic [31:0] exp_pc[$];
    int          cyc = 0;
    int          lat = 1;
    int          outst = 0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_data = NOP;
    logic        hold_valid = 1'b0;

    always @(posedge CLK) begin
        logic        adv, fl, rs;
        logic [31:0] fpc, e;
        adv = !RST && !FLUSH && !STALL && !MEM_WAIT;
        fl  = FLUSH;
        rs  = RST;
        fpc = NEW_PC;
        cyc++;
        if (rs) begin
            pend_a.delete();
            pend_due.delete();
            exp_pc.delete();
            outst = 0;
        end else begin
            if (INST_RVALID)
                outst--;
            if (fl)
                exp_pc.delete();
            if (INST_RDEN) begin
                pend_a.push_back(INST_RIADDR);
                pend_due.push_back(cyc + lat - 1);
                exp_pc.push_back(INST_RIADDR);
                outst++;
            end
        end
        #1;
        if (rs) begin
            hold_pc    = 32'h0;
            hold_data  = NOP;
            hold_valid = 1'b0;
        end else if (fl) begin
            total++;
            if (INST_VALID !== 1'b0 || INST_DATA !== NOP || INST_PC !== fpc) begin
                bad++;
                $display("FAIL flush_out: got v=%b pc=%h d=%h want v=0 pc=%h d=%h",
                         INST_VALID, INST_PC, INST_DATA, fpc, NOP);
            end
            hold_pc    = fpc;
            hold_data  = NOP;
            hold_valid = 1'b0;
        end else if (adv) begin
            total++;
            if (INST_VALID === 1'b1) begin
                if (exp_pc.size() == 0) begin
                    bad++;
                    $display("FAIL present_extra: got pc=%h want nothing queued", INST_PC);
                end else begin
                    e = exp_pc.pop_front();
                    if (INST_PC !== e || INST_DATA !== mem(e)) begin
                        bad++;
                        $display("FAIL present: got pc=%h d=%h want pc=%h d=%h",
                                 INST_PC, INST_DATA, e, mem(e));
                    end
                    hold_pc    = e;
                    hold_data  = mem(e);
                    hold_valid = 1'b1;
                end
            end else begin
                if (INST_PC !== hold_pc || INST_DATA !== NOP) begin
                    bad++;
                    $display("FAIL idle_out: got pc=%h d=%h want pc=%h d=%h",
                             INST_PC, INST_DATA, hold_pc, NOP);
                end
                hold_data  = NOP;
                hold_valid = 1'b0;
            end
        end else begin
            total++;
            if (INST_PC !== hold_pc || INST_DATA !== hold_data
                || INST_VALID !== hold_valid) begin
                bad++;
                $display("FAIL hold: got v=%b pc=%h d=%h want v=%b pc=%h d=%h",
                         INST_VALID, INST_PC, INST_DATA,
                         hold_valid, hold_pc, hold_data);
            end
        end
        total++;
        if (outst > D || exp_pc.size() > D) begin
            bad++;
            $display("FAIL credit: got outstanding=%0d pending=%0d want <=%0d",
                     outst, exp_pc.size(), D);
        end
        if (rs || pend_due.size() == 0 || pend_due[0] > cyc) begin
            INST_RVALID = 1'b0;
            INST_ROADDR = 32'h0;
            INST_RDATA  = 32'h0;
        end else begin
            e = pend_a.pop_front();
            void'(pend_due.pop_front());
            INST_RVALID = 1'b1;
            INST_ROADDR = e;
            INST_RDATA  = mem(e);
        end
    end

    // latency-1 memory + scoreboard for the DEPTH=2 instance
    logic [31:0] p2[$];
    logic [31:0] e2[$];
    logic [31:0] req2[4];
    int          n2req = 0;
    int          o2 = 0;
    int          max2 = 0;
    int          pres2 = 0;

    always @(posedge CLK) begin
        logic        rs;
        logic [31:0] e;
        rs = RST;
        if (rs) begin
            p2.delete();
            e2.delete();
            o2    = 0;
            n2req = 0;
        end else begin
            if (rvalid2)
                o2--;
            if (rden2) begin
                p2.push_back(riaddr2);
                e2.push_back(riaddr2);
                o2++;
                if (n2req < 4)
                    req2[n2req] = riaddr2;
                n2req++;
            end
        end
        if (o2 > max2)
            max2 = o2;
        #1;
        if (!rs && valid2 === 1'b1) begin
            total++;
            pres2++;
            if (e2.size() == 0) begin
                bad++;
                $display("FAIL d2_extra: got pc=%h want nothing queued", pc2);
            end else begin
                e = e2.pop_front();
                if (pc2 !== e || data2 !== mem(e)) begin
                    bad++;
                    $display("FAIL d2_present: got pc=%h d=%h want pc=%h d=%h",
                             pc2, data2, e, mem(e));
                end
            end
        end
        if (rs || p2.size() == 0) begin
            rvalid2 = 1'b0;
            roaddr2 = 32'h0;
            rdata2  = 32'h0;
        end else begin
            e = p2.pop_front();
            rvalid2 = 1'b1;
            roaddr2 = e;
            rdata2  = mem(e);
        end
    end

    task automatic test_reset;
        @(negedge CLK);
        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MEM_WAIT = 1'b0;
        NEW_PC = 32'h0;
        lat = 1;
        repeat (2) @(posedge CLK);
        #2;
        total++;
        if (INST_RDEN !== 1'b0 || INST_RIADDR !== 32'h0) begin
            bad++;
            $display("FAIL rst_req: got rden=%b addr=%h want rden=0 addr=0",
                     INST_RDEN, INST_RIADDR);
        end
        total++;
        if (INST_PC !== 32'h0 || INST_DATA !== NOP || INST_VALID !== 1'b0) begin
            bad++;
            $display("FAIL rst_out: got v=%b pc=%h d=%h want v=0 pc=0 d=%h",
                     INST_VALID, INST_PC, INST_DATA, NOP);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++;
        if (INST_RDEN !== 1'b1 || INST_RIADDR !== 32'h0) begin
            bad++;
            $display("FAIL first_req: got rden=%b addr=%h want rden=1 addr=0",
                     INST_RDEN, INST_RIADDR);
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK);
            #2;
            total++;
            if (INST_VALID !== (i == 3)) begin
                bad++;
                $display("FAIL first_valid: edge %0d got v=%b want v=%b",
                         i, INST_VALID, i == 3);
            end
        end
        total++;
        if (INST_PC !== 32'h0 || INST_DATA !== mem(32'h0)) begin
            bad++;
            $display("FAIL first_inst: got pc=%h d=%h want pc=0 d=%h",
                     INST_PC, INST_DATA, mem(32'h0));
        end
    endtask

    task automatic test_stream;
        int v;
        repeat (8) @(posedge CLK);
        v = 0;
        repeat (5) begin
            @(posedge CLK);
            #2;
            if (INST_VALID === 1'b1)
                v++;
        end
        total++;
        if (v != 5) begin
            bad++;
            $display("FAIL throughput: got %0d valid of 5 want 5", v);
        end
    endtask

    task automatic test_stall;
        @(negedge CLK);
        STALL = 1'b1;
        repeat (6) @(posedge CLK);
        #2;
        total++;
        if (INST_RDEN !== 1'b0) begin
            bad++;
            $display("FAIL stall_rden: got rden=%b want 0", INST_RDEN);
        end
        @(negedge CLK);
        STALL = 1'b0;
        repeat (8) @(posedge CLK);
    endtask

    task automatic test_flush;
        int n;
        bit ok;
        @(negedge CLK);
        lat = 2;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (outst >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL flush_setup: got outstanding=%0d want >=2", outst);
        end
        FLUSH  = 1'b1;
        NEW_PC = 32'h0000_0100;
        @(negedge CLK);
        FLUSH = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge CLK);
            #2;
            n++;
            if (INST_VALID === 1'b1)
                break;
        end
        total++;
        if (INST_VALID !== 1'b1 || INST_PC !== 32'h100
            || INST_DATA !== mem(32'h100)) begin
            bad++;
            $display("FAIL flush_target: got v=%b pc=%h d=%h want v=1 pc=100 d=%h",
                     INST_VALID, INST_PC, INST_DATA, mem(32'h100));
        end
        repeat (6) @(posedge CLK);
    endtask

    task automatic test_mem_wait;
        @(negedge CLK);
        MEM_WAIT = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (INST_RDEN !== 1'b0) begin
                bad++;
                $display("FAIL memwait_rden: cycle %0d got rden=%b want 0",
                         i, INST_RDEN);
            end
            if (i < 3) begin
                @(posedge CLK);
                #2;
            end
        end
        @(negedge CLK);
        MEM_WAIT = 1'b0;
        repeat (8) @(posedge CLK);
    endtask

    task automatic test_flush_combo;
        int n;
        bit ok;
        lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (INST_RVALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL combo_setup: got no response want one within 20");
        end
        FLUSH = 1'b1; STALL = 1'b1; MEM_WAIT = 1'b1;
        NEW_PC = 32'h0000_0200;
        @(posedge CLK);
        #2;
        total++;
        if (INST_VALID !== 1'b0 || INST_DATA !== 32'h0000_0013
            || INST_PC !== 32'h200) begin
            bad++;
            $display("FAIL combo_out: got v=%b pc=%h d=%h want v=0 pc=200 d=13",
                     INST_VALID, INST_PC, INST_DATA);
        end
        @(negedge CLK);
        FLUSH = 1'b0; STALL = 1'b0; MEM_WAIT = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge CLK);
            #2;
            n++;
            if (INST_VALID === 1'b1)
                break;
        end
        total++;
        if (INST_VALID !== 1'b1 || INST_PC !== 32'h200) begin
            bad++;
            $display("FAIL combo_target: got v=%b pc=%h want v=1 pc=200",
                     INST_VALID, INST_PC);
        end
        repeat (6) @(posedge CLK);
    endtask

    task automatic test_depth2;
        logic [31:0] want[4];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        want[3] = 32'h0000_0004;
        total++;
        if (n2req < 4) begin
            bad++;
            $display("FAIL d2_reqs: got %0d requests want >=4", n2req);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (req2[i] !== want[i]) begin
                    bad++;
                    $display("FAIL d2_addr: req %0d got %h want %h",
                             i, req2[i], want[i]);
                end
            end
        end
        total++;
        if (max2 > 2) begin
            bad++;
            $display("FAIL d2_inflight: got max=%0d want <=2", max2);
        end
        total++;
        if (pres2 < 10) begin
            bad++;
            $display("FAIL d2_presented: got %0d want >=10", pres2);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        lat = 2;
        repeat (5) @(posedge CLK);
        test_reset();
        repeat (6) @(posedge CLK);
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MEM_WAIT = 1'b0;
        NEW_PC = 32'h0;
        flush2 = 1'b0; stall2 = 1'b0; mw2 = 1'b0; newpc2 = 32'h0;
        INST_RVALID = 1'b0; INST_ROADDR = 32'h0; INST_RDATA = 32'h0;
        rvalid2 = 1'b0; roaddr2 = 32'h0; rdata2 = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_mem_wait();
        test_flush_combo();
        test_depth2();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue of configurable depth and multiple outstanding MMU requests. It replaces the single-slot fetch stage at the head of the core pipeline. It keeps issuing sequential instruction reads while decode is stalled, then releases one {PC, instruction} pair per advancing cycle to decode stage 1. It redirects on FLUSH, discarding every in-flight response that belongs to the old stream.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also bounds outstanding requests.
- START_ADDR, 32'h0000_0000: first fetch address after reset.
- NOP, 32'h0000_0013: instruction emitted when no valid entry is presented (addi x0,x0,0).

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  redirect request; highest priority.
- NEW_PC  in  32  redirect target; sampled when FLUSH=1.
- STALL  in  1  downstream hazard; hold outputs.
- MEM_WAIT  in  1  memory hazard; hold outputs, no new requests.
- INST_RDEN  out  1  read request strobe (combinational from registered state and inputs).
- INST_RIADDR  out  32  request address; valid when INST_RDEN=1.
- INST_ROADDR  in  32  address of the returning word.
- INST_RVALID  in  1  response strobe. Exactly one response per request, in order, no earlier than the cycle after the request.
- INST_RDATA  in  32  returned instruction.
- INST_PC  out  32  PC of presented instruction.
- INST_DATA  out  32  presented instruction.
- INST_VALID  out  1  presented pair is a real fetched instruction.

## Operation
- State: fetch_pc, circular queue (rd/wr pointers, count 0..DEPTH), inflight counter, drop counter (counter width clog2(DEPTH)+1).
- Issue:
  - INST_RDEN=1 iff !RST && !FLUSH && !MEM_WAIT && count+inflight < DEPTH (registered values).
  - INST_RIADDR=fetch_pc.
  - On issue: fetch_pc += 4 (wraps mod 2^32), inflight += 1.
- Response, when INST_RVALID=1:
  - inflight -= 1.
  - If drop>0 or FLUSH=1 that cycle: discard. drop -= 1 when drop>0.
  - Otherwise push {INST_ROADDR, INST_RDATA}.
  - Overflow is impossible by the credit rule.
- Present:
  - FLUSH=1: INST_VALID=0, INST_DATA=NOP, INST_PC=NEW_PC.
  - Else STALL=1 or MEM_WAIT=1: all outputs held; no pop.
  - Else count>0: pop head into INST_PC/INST_DATA, INST_VALID=1.
  - Else: INST_VALID=0, INST_DATA=NOP, INST_PC held.
- FLUSH handling:
  - Queue cleared (count=0, pointers reset).
  - fetch_pc=NEW_PC.
  - drop = inflight minus one if a response is discarded the same cycle.
  - inflight counter keeps counting stale requests, so their credits are returned only as they drain.
  - FLUSH overrides STALL, MEM_WAIT and any simultaneous push/pop.
- Push and pop in the same cycle are both performed; count is unchanged. No bypass: a response is never presented in the cycle it arrives.
- Reset values: INST_RDEN=0, INST_RIADDR=START_ADDR, INST_PC=0, INST_DATA=NOP, INST_VALID=0, count=inflight=drop=0, fetch_pc=START_ADDR.

## Timing
- Reset released at edge 0: first INST_RDEN=1 (RIADDR=START_ADDR) in cycle 0 unless MEM_WAIT.
- Response in cycle c enters the queue at edge c+1. With no stall it is presented after edge c+2.
- Throughput: one request and one presented instruction per cycle in steady state when response latency L satisfies L+1 < DEPTH.
- FLUSH in cycle f:
  - Outputs show INST_VALID=0 after edge f+1.
  - First request to NEW_PC is issued in cycle f+1 if credits allow (count=0, inflight may still hold stale requests).
  - First new-stream instruction is presented no earlier than edge f+L+3.
- Count full (count=DEPTH) with STALL: INST_RDEN=0 until a pop frees a slot. The freed credit is usable one cycle after the pop.
- RST during an outstanding request resets all counters. Responses arriving after reset are treated as new-stream data. The MMU is reset together with this block, so no stale response arrives after reset.

## Test plan
- Reset, DEPTH=4, latency 1, no stalls: RDEN at 0x0, 0x4, 0x8… every cycle; INST_PC sequence 0x0, 0x4, 0x8 with VALID=1 from the third edge.
- STALL held 6 cycles: outputs frozen; RDEN stops once count+inflight=4; after release, PCs continue with no gap or duplicate.
- Latency 2, two requests in flight (0x10, 0x14), FLUSH with NEW_PC=0x100: both stale responses dropped; next valid INST_PC=0x100 with its data; no 0x10/0x14 presented.
- MEM_WAIT=1 for 3 cycles with responses arriving: RDEN=0, outputs held, responses still queued; after MEM_WAIT=0 the queued PCs are presented in order.
- FLUSH coincident with STALL, MEM_WAIT and INST_RVALID: response discarded, INST_VALID=0, INST_DATA=0x00000013, INST_PC=NEW_PC next cycle.
- DEPTH=2, fetch_pc=0xFFFFFFFC: next request address wraps to 0x00000000; inflight never exceeds 2.
